ldpc_llr_row_loader: RTL and testbench
======================================

# ldpc_llr_row_loader

Serial-to-parallel row assembler that sits directly upstream of the check node processing unit (`ldpc_cpu`) in the GF(257) 4x24 LDPC decoder. It accepts one two's-complement LLR per cycle over a valid/ready stream and converts each one to the sign-magnitude format the CPU consumes. It groups the LLRs into rows of ROW_WEIGHT values, double-buffers complete rows, and presents each row in parallel with a valid/ready handshake. Framing errors are detected from `s_last` and reported on a sticky flag.

## Interface
- LLR_WIDTH, 8, bit width of each LLR on both the input and output side.
- ROW_WEIGHT, 24, number of LLRs per row, equal to the CPU's lane count.

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- s_valid  in  1  input LLR is valid.
- s_ready  out  1  loader can accept an input LLR.
- s_data  in  LLR_WIDTH  input LLR, two's complement.
- s_last  in  1  marks the final LLR of a row.
- row_valid  out  1  `row_llr` holds a complete row.
- row_ready  in  1  downstream accepts the row; drive it from the CPU `en`.
- row_llr  out  LLR_WIDTH*ROW_WEIGHT  parallel row in sign-magnitude; lane k occupies bits [k*LLR_WIDTH +: LLR_WIDTH].
- err_len  out  1  sticky framing-error flag.

## Operation
- Input accept: an LLR is accepted when `s_valid && s_ready`.
- Lane order: lane k holds the k-th LLR accepted in the current row, so lane 0 is the first accepted.
- Format conversion, with W = LLR_WIDTH:
  - Output MSB is the sign; the low W-1 bits are the magnitude.
  - Non-negative x maps to {0, x[W-2:0]}.
  - Negative x maps to {1, -x}.
  - The most negative value, -2^(W-1), saturates to {1, all-ones}; for W=8, 0x80 becomes 0xFF.
  - Zero always maps to 0x00; negative zero is never produced.
- Index counter `idx` runs 0..ROW_WEIGHT-1 and advances on each accept.
- Row completion: an accept at idx = ROW_WEIGHT-1 with `s_last` = 1 completes the row. The fill bank is marked full, the write bank toggles, and idx returns to 0.
- Framing errors, all treated the same way:
  - `s_last` = 1 at idx < ROW_WEIGHT-1, or `s_last` = 0 at idx = ROW_WEIGHT-1.
  - Response: the partial row is discarded, idx returns to 0, `err_len` is set, and no row is emitted.
  - The next accepted LLR starts a new row.
- Double buffer: two banks, a write pointer, a read pointer and an occupancy FSM.
  - EMPTY: no full bank; `row_valid` = 0.
  - ONE: one full bank; `row_valid` = 1.
  - TWO: both banks full; `row_valid` = 1 and `s_ready` = 0.
- FSM transitions:
  - A row completion alone moves the FSM up one state.
  - A row pop (`row_valid && row_ready`) alone moves it down one state.
  - A completion and a pop in the same cycle leave the state unchanged; both pointers advance.
- `s_ready` = 1 in EMPTY and ONE, and 0 in TWO.
- Output hold: `row_llr` shows the bank at the read pointer. It must stay stable while `row_valid && !row_ready`.
- `err_len` clears only on reset.

## Timing
- Reset values: `s_ready`=0 during reset and 1 in the first cycle after reset; `row_valid`=0; `row_llr`=0; `err_len`=0; idx=0; both pointers=0; FSM=EMPTY.
- Latency: `row_valid` rises in the cycle after the accept that completes the row.
- Throughput: with `row_ready` held high, the loader sustains 1 LLR per cycle with no bubbles between rows.
- Each row occupies `row_valid` for at least 1 cycle; back-to-back rows appear on consecutive pop cycles.
- `s_ready` is registered. It falls in the cycle after the completion that fills the second bank, unless that same cycle also pops a row.
- Reset mid-row or mid-hold: all partial and full rows are lost, and the outputs return to their reset values on the next edge.

## Test plan
- Reset check: hold `rst_n`=0 for 5 cycles, then release. Required: `s_ready`=1, `row_valid`=0, `err_len`=0, `row_llr`=0.
- Basic row: with `row_ready`=1, stream s_data=0..23 back-to-back with `s_last` on the 24th. Required: `row_valid` asserted the next cycle for exactly 1 cycle, lane k = k, and `err_len`=0.
- Conversion: one row with lanes 0..3 = 0xFB, 0x80, 0x7F, 0x00 and the rest 0x01. Required: lanes 0..3 = 0x85, 0xFF, 0x7F, 0x00, and lanes 4..23 = 0x01.
- Backpressure: hold `row_ready`=0 and offer 3 rows tagged by a value (row r, lane 0 = r). Required:
  - `s_ready` drops after the 48th accept and the third row stalls.
  - After raising `row_ready`, the rows emerge in the order 0, 1, 2 with no lost or duplicated LLRs.
  - `row_llr` stays stable while stalled.
- Framing errors: assert `s_last` on the 10th LLR, then send a correct 24-LLR row. Required: `err_len`=1 and stays set; exactly one `row_valid`, carrying the second row. Repeat with `s_last` missing on the 24th LLR and require the same result.
- Reset mid-row: accept 12 LLRs, assert `rst_n`=0 for 1 cycle, then send a full row. Required: one row, containing only the post-reset data.

Source files
------------

// File: rtl/ldpc_llr_row_loader.sv
// ldpc_llr_row_loader: packs serial two's-complement LLRs into double-buffered sign-magnitude rows
module ldpc_llr_row_loader #(
  parameter int LLR_WIDTH  = 8,
  parameter int ROW_WEIGHT = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [LLR_WIDTH-1:0]            s_data,
  input  logic                            s_last,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [LLR_WIDTH*ROW_WEIGHT-1:0] row_llr,
  output logic                            err_len
);
  localparam int IW = $clog2(ROW_WEIGHT);
  localparam logic [IW-1:0] LAST = IW'(ROW_WEIGHT - 1);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic wr_ptr, rd_ptr;
  logic [LLR_WIDTH-1:0] bank [2][ROW_WEIGHT];
  logic [LLR_WIDTH-1:0] neg, sm;
  logic acc, at_last, done, pop;
  assign acc = s_valid && s_ready;
  assign at_last = idx == LAST;
  assign done = acc && at_last && s_last;
  assign pop = row_valid && row_ready;
  assign neg = -s_data;
  // negating the most negative value wraps back to itself, so its MSB flags saturation
  assign sm = !s_data[LLR_WIDTH-1] ? s_data : (neg[LLR_WIDTH-1] ? '1 : {1'b1, neg[LLR_WIDTH-2:0]});
  always_ff @(posedge clk)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (done && !pop) state_nxt = (state == EMPTY) ? ONE : TWO;
    else if (pop && !done) state_nxt = (state == TWO) ? ONE : EMPTY;
  end
  always_comb row_valid = state != EMPTY;
  always_ff @(posedge clk)
    if (!rst_n) begin
      s_ready <= 1'b0;
      idx <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      err_len <= 1'b0;
    end else begin
      s_ready <= state_nxt != TWO;
      if (acc) idx <= (s_last || at_last) ? '0 : idx + 1'b1;
      if (acc && (s_last != at_last)) err_len <= 1'b1;
      if (done) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
    end
  // a framing error only rewinds idx; stale lanes are overwritten by the next row
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < ROW_WEIGHT; k++)
          bank[b][k] <= '0;
    end else if (acc) bank[wr_ptr][idx] <= sm;
  for (genvar k = 0; k < ROW_WEIGHT; k++) begin : g_lane
    assign row_llr[k*LLR_WIDTH +: LLR_WIDTH] = bank[rd_ptr][k];
  end
endmodule

// File: tb/tb_ldpc_llr_row_loader.sv
// tb_ldpc_llr_row_loader: randomized scoreboard bench for the LLR row loader
module tb_ldpc_llr_row_loader;
  localparam int W = 8;
  localparam int M = W - 1;
  localparam int RW = 24;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, row_ready = 0;
  logic s_ready, row_valid, err_len;
  logic [W-1:0] s_data = '0;
  logic [W*RW-1:0] row_llr;
  int n_cmp = 0, n_bad = 0, acc_cnt = 0;
  bit exp_err = 0, holding = 0, rnd_done = 0;
  logic [W-1:0] cur[$];
  logic [W*RW-1:0] exp_q[$];
  logic [W*RW-1:0] held, mrow;

  ldpc_llr_row_loader #(.LLR_WIDTH(W), .ROW_WEIGHT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .row_valid(row_valid), .row_ready(row_ready), .row_llr(row_llr),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_sm(input logic [W-1:0] x);
    int v;
    v = $signed(x);
    if (v == -(1 << (W - 1))) return '1;
    if (v < 0) return {1'b1, M'(-v)};
    return x;
  endfunction

  task automatic check(input string nm, input logic [W*RW-1:0] act, input logic [W*RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: collect accepted LLRs, emit a row only on a well-framed 24th
  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      exp_err = 0;
    end else if (s_valid && s_ready) begin
      acc_cnt++;
      cur.push_back(to_sm(s_data));
      if (s_last || cur.size() == RW) begin
        if (s_last && cur.size() == RW) begin
          foreach (cur[k]) mrow[k*W +: W] = cur[k];
          exp_q.push_back(mrow);
        end else exp_err = 1;
        cur.delete();
      end
    end
  end

  // monitor: pop and compare on every row handshake, and check stability while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (holding) begin
        check("hold_valid", row_valid, 1'b1);
        check("hold_stable", row_llr, held);
      end
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_row: got %h expected no row", row_llr);
        end else check("row", row_llr, exp_q.pop_front());
      end
      holding = row_valid && !row_ready;
      held = row_llr;
    end else holding = 0;
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    bit ok;
    int t;
    s_valid = 1;
    s_data = d;
    s_last = l;
    t = 0;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected acceptance", t);
    end
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    wait_cycles(4);
    check("reset_sready_low", s_ready, 1'b0);
    wait_cycles(1);
    rst_n = 1;
    wait_cycles(1);
    check("reset_sready", s_ready, 1'b1);
    check("reset_row_valid", row_valid, 1'b0);
    check("reset_err", err_len, 1'b0);
    check("reset_row_llr", row_llr, '0);
    row_ready = 1;
    for (int i = 0; i < RW; i++) send(W'(i), i == RW - 1);
    check("basic_latency", row_valid, 1'b1);
    wait_cycles(1);
    check("basic_one_cycle", row_valid, 1'b0);
    check("basic_err", err_len, 1'b0);
    for (int i = 0; i < RW; i++)
      send(i == 0 ? 8'hFB : i == 1 ? 8'h80 : i == 2 ? 8'h7F : i == 3 ? 8'h00 : 8'h01, i == RW - 1);
    check("conv_lanes0_3", row_llr[31:0], 32'h007FFF85);
    check("conv_lane4", row_llr[39:32], 8'h01);
    wait_cycles(2);
    row_ready = 0;
    begin
      int base;
      base = acc_cnt;
      fork
        for (int r = 0; r < 3; r++)
          for (int i = 0; i < RW; i++) send(i == 0 ? W'(r) : W'($urandom), i == RW - 1);
        begin
          int t;
          t = 0;
          while (acc_cnt < base + 48 && t < 500) begin
            @(posedge clk);
            t++;
          end
          repeat (5) @(negedge clk);
          check("bp_sready", s_ready, 1'b0);
          check("bp_stall_count", acc_cnt - base, 48);
          check("bp_row_valid", row_valid, 1'b1);
          @(posedge clk);
          #1;
          row_ready = 1;
        end
      join
    end
    wait_cycles(5);
    check("bp_drained", exp_q.size(), 0);
    for (int i = 0; i < 10; i++) send(W'(100 + i), i == 9);
    for (int i = 0; i < RW; i++) send(W'($urandom), i == RW - 1);
    wait_cycles(3);
    check("err_early_last", err_len, 1'b1);
    check("err_model", err_len, exp_err);
    check("err_early_drained", exp_q.size(), 0);
    for (int i = 0; i < RW; i++) send(W'(50 + i), 1'b0);
    for (int i = 0; i < RW; i++) send(W'($urandom), i == RW - 1);
    wait_cycles(3);
    check("err_missing_last", err_len, 1'b1);
    check("err_missing_drained", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) send(W'(200 + i), 1'b0);
    rst_n = 0;
    wait_cycles(1);
    rst_n = 1;
    check("rst_mid_err", err_len, 1'b0);
    check("rst_mid_valid", row_valid, 1'b0);
    for (int i = 0; i < RW; i++) send(W'($urandom), i == RW - 1);
    wait_cycles(3);
    check("rst_mid_drained", exp_q.size(), 0);
    fork
      begin
        for (int r = 0; r < 30; r++) begin
          int mode, cut;
          mode = $urandom_range(0, 9);
          cut = $urandom_range(0, RW - 2);
          for (int i = 0; i < RW; i++) begin
            if (mode == 0 && i > cut) break;
            send(W'($urandom), mode == 0 ? i == cut : mode == 1 ? 1'b0 : i == RW - 1);
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 2));
          end
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1;
        row_ready = $urandom_range(0, 2) != 0;
      end
    join
    row_ready = 1;
    wait_cycles(10);
    check("rand_err", err_len, exp_err);
    check("rand_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
